kbd_event_rx: RTL

Parametrised PS/2 keyboard receiver: the next generation of the team's single-scancode release detector. Deserialises PS/2 device-to-host frames, checks parity, start and stop bits, decodes E0 (extended) and F0 (break) prefixes, and queues make/break events in a small FIFO drained through a valid/ready handshake. A configurable key-match table raises a one-cycle `check` pulse on release of any listed key. Sits between the board PS/2 pins and the game/control logic.

---
 rtl/kbd_pkg.sv | 19 +
 rtl/kbd_evt_fifo.sv | 46 ++++
 rtl/kbd_event_rx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard event receiver.
package kbd_pkg;

   localparam logic [7:0] PS2_E0 = 8'hE0;
   localparam logic [7:0] PS2_F0 = 8'hF0;
   localparam int         EVT_W  = 10;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } rx_state_e;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } kbd_evt_t;

endpackage

// File: rtl/kbd_evt_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module kbd_evt_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int           AW      = $clog2(DEPTH);
   localparam logic [AW:0]  PTR_ONE = 1;

   logic [AW:0]      wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push, do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   // Masked so the head reads as zero whenever nothing is queued.
   assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/kbd_event_rx.sv
// PS/2 device-to-host receiver: filters the clock, frames bytes, decodes E0/F0
// prefixes into make/break events, queues them and flags releases of table keys.
module kbd_event_rx
   import kbd_pkg::*;
#(
   parameter int                    FILTER_LEN  = 8,
   parameter int                    FIFO_DEPTH  = 4,
   parameter int                    TIMEOUT_CYC = 50000,
   parameter int                    NUM_KEYS    = 4,
   parameter logic [NUM_KEYS*8-1:0] KEY_CODES   = {8'h2b, 8'h15, 8'h33, 8'h22}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ps2clk,
   input  logic             ps2data,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [EVT_W-1:0] evt_data,
   output logic             check,
   output logic [2:0]       key_idx,
   output logic             par_err,
   output logic             ovf,
   input  logic             clr_err
);

   localparam int HALF = FILTER_LEN / 2;
   localparam int TW   = $clog2(TIMEOUT_CYC + 1);

   logic [FILTER_LEN-1:0] filt;
   logic                  d_s1, d_s2;
   logic                  fall_edge;

   rx_state_e   state, state_nxt;
   logic [3:0]  cnt;
   logic [9:0]  sh;
   logic [TW-1:0] tmo;
   logic        frame_done, tmo_hit, frame_ok;
   logic [7:0]  code;

   logic        ext_pend, brk_pend;
   kbd_evt_t    evt;
   logic        push, pop, full, empty;
   logic        key_hit, match;
   logic [2:0]  hit_idx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt <= '0;
         d_s1 <= 1'b0;
         d_s2 <= 1'b0;
      end else begin
         filt <= {filt[FILTER_LEN-2:0], ps2clk};
         d_s1 <= ps2data;
         d_s2 <= d_s1;
      end
   end

   // Older half settled high, newer half settled low: one clean falling edge.
   assign fall_edge = (&filt[FILTER_LEN-1:HALF]) && !(|filt[HALF-1:0]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      frame_done = 1'b0;
      tmo_hit    = 1'b0;
      case (state)
         ST_IDLE:  if (fall_edge) state_nxt = ST_SHIFT;
         ST_SHIFT: begin
            if (fall_edge && cnt == 4'd10) begin
               state_nxt  = ST_IDLE;
               frame_done = 1'b1;
            end else if (!fall_edge && tmo == TW'(TIMEOUT_CYC - 1)) begin
               state_nxt = ST_IDLE;
               tmo_hit   = 1'b1;
            end
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         sh  <= '0;
         tmo <= '0;
      end else if (frame_done || tmo_hit) begin
         cnt <= '0;
         tmo <= '0;
      end else if (fall_edge) begin
         sh  <= {d_s2, sh[9:1]};
         cnt <= cnt + 4'd1;
         tmo <= '0;
      end else if (state == ST_SHIFT) begin
         tmo <= tmo + TW'(1);
      end
   end

   // After ten shifts: sh[0] start, sh[8:1] data LSB first, sh[9] parity; stop is live.
   assign code     = sh[8:1];
   assign frame_ok = !sh[0] && d_s2 && (^sh[9:1]);
   assign push     = frame_done && frame_ok && (code != PS2_E0) && (code != PS2_F0);
   assign evt      = '{ext: ext_pend, brk: brk_pend, code: code};

   always_comb begin
      key_hit = 1'b0;
      hit_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (KEY_CODES[8*i +: 8] == code) begin
            key_hit = 1'b1;
            hit_idx = 3'(i);
         end
      end
   end

   assign match = push && brk_pend && !ext_pend && key_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (tmo_hit || (frame_done && !frame_ok)) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (frame_done) begin
         if (code == PS2_E0)      ext_pend <= 1'b1;
         else if (code == PS2_F0) brk_pend <= 1'b1;
         else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         check   <= 1'b0;
         key_idx <= '0;
      end else begin
         check   <= match;
         key_idx <= match ? hit_idx : 3'd0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         par_err <= 1'b0;
         ovf     <= 1'b0;
      end else if (clr_err) begin
         par_err <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         if (frame_done && !frame_ok) par_err <= 1'b1;
         if (push && full && !pop)    ovf     <= 1'b1;
      end
   end

   assign evt_valid = !empty;
   assign pop       = evt_valid && evt_ready;

   kbd_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVT_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (evt),
      .dout  (evt_data),
      .full  (full),
      .empty (empty)
   );

endmodule
